// File: rtl/shift_add_mult_ctrl.sv
// Sequencer for an unsigned shift-add multiplier driving an external right-shift register.
// The accumulator ends holding the product high half; the external register holds the low half.
module shift_add_mult_ctrl #(
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clear,
  input  logic [DATA_SIZE-1:0] a,
  input  logic [DATA_SIZE-1:0] b,
  input  logic                 sr_q0,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_SIZE-1:0] product_hi,
  output logic                 sr_en,
  output logic                 sr_shift_load,
  output logic [DATA_SIZE-1:0] sr_d,
  output logic                 sr_d_shift
);

  localparam int CW = $clog2(DATA_SIZE) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_SIZE - 1);

  logic [1:0]           state_q, state_d;
  logic [DATA_SIZE-1:0] a_q, a_d;
  logic [DATA_SIZE-1:0] b_q, b_d;
  logic [DATA_SIZE-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_SIZE:0]   addend;
  logic [DATA_SIZE:0]   sum;

  // One extra bit keeps the carry, which becomes the accumulator MSB after the shift.
  always_comb begin
    addend = sr_q0 ? {1'b0, a_q} : '0;
    sum    = {1'b0, acc_q} + addend;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_d     = a;
            b_d     = b;
            acc_d   = '0;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
        S_SHIFT: begin
          acc_d = sum[DATA_SIZE:1];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Control outputs decode from the state register alone.
  assign busy          = (state_q == S_LOAD) || (state_q == S_SHIFT);
  assign done          = (state_q == S_DONE);
  assign sr_en         = busy;
  assign sr_shift_load = (state_q == S_SHIFT);
  assign sr_d          = b_q;
  assign sr_d_shift    = sum[0];
  assign product_hi    = acc_q;

endmodule
